// File: rtl/pattern_loader_if.sv
// Host stream channel feeding the pattern loader: 16-bit words with valid/ready handshake.
interface pattern_loader_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pattern_loader.sv
// Host-side writer for the double-buffered pattern memory: decodes the host command
// stream, writes state/mode words into the idle buffer and drives sequencer controls.
module pattern_loader #(
    parameter int BUF_WORDS = 2048,
    parameter int DAW       = 12,
    parameter int VAW       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pattern_loader_if.slave      host,
    input  logic                 active_buffer,
    input  logic                 preload,
    input  logic                 active,
    output logic                 dwe,
    output logic [DAW-1:0]       dwaddr,
    output logic [31:0]          dwdata,
    output logic                 vwe,
    output logic [VAW-1:0]       vwaddr,
    output logic [31:0]          vwdata,
    output logic                 ready,
    output logic                 switch,
    output logic                 stop,
    output logic                 err
);
    localparam logic [2:0] HDR     = 3'd0;
    localparam logic [2:0] HOLD    = 3'd1;
    localparam logic [2:0] DATA_HI = 3'd2;
    localparam logic [2:0] DATA_LO = 3'd3;
    localparam logic [2:0] VAR_HI  = 3'd4;
    localparam logic [2:0] VAR_LO  = 3'd5;
    localparam logic [2:0] DRAIN   = 3'd6;

    localparam logic [3:0] CMD_LOAD_DATA = 4'd1;
    localparam logic [3:0] CMD_LOAD_VAR  = 4'd2;
    localparam logic [3:0] CMD_COMMIT    = 4'd3;
    localparam logic [3:0] CMD_STOP      = 4'd4;
    localparam logic [3:0] CMD_CLRERR    = 4'd5;

    localparam int IW = DAW - 1;

    logic [2:0]    state;
    logic [15:0]   hdr_q;
    logic [15:0]   hi_q;
    logic          tgt;
    logic [IW-1:0] idx;
    logic [11:0]   pairs_left;
    logic [12:0]   drain_left;
    logic          preload_q;

    logic          fire;
    logic          blocked;
    logic          gated_cmd;
    logic          do_disp;
    logic [3:0]    in_cmd;
    logic [15:0]   disp_hdr;
    logic [3:0]    disp_cmd;
    logic [11:0]   disp_len;
    logic          len_ovf;

    assign host.in_ready = !reset && (state != HOLD);

    // A header waiting in HOLD is dispatched from hdr_q through the same path as a live one.
    always_comb begin
        fire      = host.in_valid & host.in_ready;
        blocked   = switch | (ready & ~active);
        in_cmd    = host.in_data[15:12];
        gated_cmd = (in_cmd == CMD_LOAD_DATA) || (in_cmd == CMD_LOAD_VAR) ||
                    (in_cmd == CMD_COMMIT);
        disp_hdr  = (state == HOLD) ? hdr_q : host.in_data;
        disp_cmd  = disp_hdr[15:12];
        disp_len  = disp_hdr[11:0];
        len_ovf   = {1'b0, disp_len} > 13'(BUF_WORDS);
        do_disp   = !blocked && (((state == HDR) && fire && gated_cmd) || (state == HOLD));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HDR;
            hdr_q      <= '0;
            hi_q       <= '0;
            tgt        <= 1'b0;
            idx        <= '0;
            pairs_left <= '0;
            drain_left <= '0;
            preload_q  <= 1'b0;
            dwe        <= 1'b0;
            dwaddr     <= '0;
            dwdata     <= '0;
            vwe        <= 1'b0;
            vwaddr     <= '0;
            vwdata     <= '0;
            ready      <= 1'b0;
            switch     <= 1'b0;
            stop       <= 1'b0;
            err        <= 1'b0;
        end else begin
            dwe       <= 1'b0;
            vwe       <= 1'b0;
            stop      <= 1'b0;
            preload_q <= preload;
            // Placed first so that a COMMIT in the same cycle overrides the clear.
            if (preload && !preload_q)
                switch <= 1'b0;

            if (do_disp) begin
                case (disp_cmd)
                    CMD_LOAD_DATA: begin
                        if (len_ovf) begin
                            err        <= 1'b1;
                            drain_left <= {disp_len, 1'b0};
                            state      <= DRAIN;
                        end else if (disp_len == 12'd0) begin
                            state <= HDR;
                        end else begin
                            tgt        <= ~active_buffer;
                            idx        <= '0;
                            pairs_left <= disp_len;
                            state      <= DATA_HI;
                        end
                    end
                    CMD_LOAD_VAR: begin
                        tgt   <= ~active_buffer;
                        state <= VAR_HI;
                    end
                    default: begin
                        if (!active)
                            ready <= 1'b1;
                        else
                            switch <= 1'b1;
                        state <= HDR;
                    end
                endcase
            end else begin
                case (state)
                    HDR: begin
                        if (fire) begin
                            if (gated_cmd) begin
                                hdr_q <= host.in_data;
                                state <= HOLD;
                            end else if (in_cmd == CMD_STOP) begin
                                stop   <= 1'b1;
                                ready  <= 1'b0;
                                switch <= 1'b0;
                            end else if (in_cmd == CMD_CLRERR) begin
                                err <= 1'b0;
                            end
                        end
                    end
                    HOLD: ;
                    DATA_HI: begin
                        if (fire) begin
                            hi_q  <= host.in_data;
                            state <= DATA_LO;
                        end
                    end
                    DATA_LO: begin
                        if (fire) begin
                            dwe        <= 1'b1;
                            dwaddr     <= {tgt, idx};
                            dwdata     <= {hi_q, host.in_data};
                            idx        <= idx + 1'b1;
                            pairs_left <= pairs_left - 1'b1;
                            state      <= (pairs_left == 12'd1) ? HDR : DATA_HI;
                        end
                    end
                    VAR_HI: begin
                        if (fire) begin
                            hi_q  <= host.in_data;
                            state <= VAR_LO;
                        end
                    end
                    VAR_LO: begin
                        if (fire) begin
                            vwe    <= 1'b1;
                            vwaddr <= {{(VAW-1){1'b0}}, tgt};
                            vwdata <= {hi_q, host.in_data};
                            state  <= HDR;
                        end
                    end
                    DRAIN: begin
                        if (fire) begin
                            drain_left <= drain_left - 1'b1;
                            if (drain_left == 13'd1)
                                state <= HDR;
                        end
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end
endmodule
